// File: rtl/lsu_ctrl_if.sv
// Core-side and memory-side signals of the load/store unit.
// The master modport is the LSU's view; slave is the core/memory environment.
interface lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic                  mem_req;
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_ack;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
           mem_rd_data, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
           mem_rd_data, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_wr_en, mem_funct3, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store initiator: core request -> legality check -> memory access -> response.
// Optional access timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.master bus,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid and its payload stay stable until that edge; ready never depends on valid.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state;
  logic   we_q;

  assign dbg_state = state;

  function automatic logic is_legal(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      we_q             <= 1'b0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_err     <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_wr_en    <= 1'b0;
      bus.mem_funct3   <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wr_data  <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q            <= bus.req_we;
            bus.mem_funct3  <= bus.req_funct3;
            bus.mem_addr    <= bus.req_addr;
            bus.mem_wr_data <= bus.req_wdata;
            bus.req_ready   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
            if (is_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
              bus.mem_req   <= 1'b1;
              bus.mem_wr_en <= bus.req_we;
              state         <= S_ACCESS;
            end else begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= S_RESP;
            end
          end
        end

        S_ACCESS: begin
          if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= we_q ? '0 : bus.mem_rd_data;
            state          <= S_RESP;
          end
`ifdef LSU_TIMEOUT_EN
          // An ack in the last allowed cycle is taken above, ahead of the timeout.
          else if (tmo_cnt == LAST) begin
            bus.mem_req    <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            state          <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table of single transactions plus
// multi-cycle sequences (backpressure, wait states, mid-access reset, timeout).
module tb_lsu_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Memory model: word array, ack gated by bench controls.
  logic          ack_auto = 1'b1;
  logic          ack_manual = 1'b0;
  logic          force_rd = 1'b0;
  logic [31:0]   rd_val = 32'h0;
  logic          mem_clear = 1'b1;
  logic [31:0]   mem_arr [16];
  int            req_cycles = 0;
  int            wr_cycles = 0;

  assign bus.mem_ack     = bus.mem_req & (ack_auto | ack_manual);
  assign bus.mem_rd_data = force_rd ? rd_val : mem_arr[bus.mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_req && bus.mem_ack && bus.mem_wr_en) begin
      mem_arr[bus.mem_addr[5:2]] <= bus.mem_wr_data;
    end
    if (bus.mem_req)   req_cycles <= req_cycles + 1;
    if (bus.mem_wr_en) wr_cycles  <= wr_cycles + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present a request and return just after the edge that accepted it.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat, r0, w0, n;
    logic [31:0] snap;

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};        // SW
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF}; // LW
    vecs[2]  = '{1'b0, 3'b001, 32'h13, 32'h0,        1'b1, 32'h0};        // LH misaligned
    vecs[3]  = '{1'b1, 3'b010, 32'h12, 32'h5A5A5A5A, 1'b1, 32'h0};        // SW misaligned
    vecs[4]  = '{1'b0, 3'b011, 32'h00, 32'h0,        1'b1, 32'h0};        // illegal load
    vecs[5]  = '{1'b1, 3'b000, 32'h21, 32'h00000055, 1'b0, 32'h0};        // SB odd
    vecs[6]  = '{1'b1, 3'b100, 32'h20, 32'h0,        1'b1, 32'h0};        // illegal store
    vecs[7]  = '{1'b0, 3'b101, 32'h22, 32'h0,        1'b0, 32'h00000055}; // LHU
    vecs[8]  = '{1'b1, 3'b001, 32'h06, 32'h00001234, 1'b0, 32'h0};        // SH
    vecs[9]  = '{1'b0, 3'b000, 32'h03, 32'h0,        1'b0, 32'h10000000}; // LB
    vecs[10] = '{1'b1, 3'b010, 32'h11, 32'h0,        1'b1, 32'h0};        // SW misaligned
    vecs[11] = '{1'b0, 3'b010, 32'h18, 32'h0,        1'b0, 32'h10000006}; // LW
    vecs[12] = '{1'b0, 3'b010, 32'h04, 32'h0,        1'b0, 32'h00001234}; // LW after SH

    // Clock/reset
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_req",    32'(bus.mem_req),    32'd0);
    chk("rst_mem_wr_en",  32'(bus.mem_wr_en),  32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_mem_addr",   bus.mem_addr,        32'd0);
    chk("rst_state",      32'(dbg_state),      32'd0);
    @(negedge clk);
    mem_clear = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, zero-wait memory
    for (int i = 0; i < 13; i++) begin
      r0 = req_cycles; w0 = wr_cycles;
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      lat = 1;
      while (!bus.resp_valid && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("v%0d_err", i),   32'(bus.resp_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), bus.resp_rdata,    vecs[i].rdata);
      chk($sformatf("v%0d_lat", i),   32'(lat),          vecs[i].err ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      chk($sformatf("v%0d_req_cycles", i), 32'(req_cycles - r0), vecs[i].err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_wr_cycles", i),  32'(wr_cycles - w0),
          (!vecs[i].err && vecs[i].we) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_idle", i), 32'({bus.req_ready, bus.resp_valid}), 32'b10);
    end

    // Response backpressure with a second request waiting
    bus.resp_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("bp_first_valid", 32'(bus.resp_valid), 32'd1);
    issue_hold: begin
      bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h18;
      bus.req_valid = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k),
          {bus.resp_rdata[31:2], bus.resp_valid, bus.req_ready},
          {30'(32'hDEADBEEF >> 2), 1'b1, 1'b0});
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'({bus.req_ready, bus.resp_valid, dbg_state}), 32'b1000);
    @(posedge clk); #1;
    chk("bp_second_accept", 32'({bus.req_ready, bus.mem_req, dbg_state}), 32'b0101);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_second_rdata", bus.resp_rdata, 32'h10000006);
    @(posedge clk); #1;

    // Wait-state access: ack arrives in the 6th ACCESS cycle
    ack_auto = 1'b0; force_rd = 1'b1; rd_val = 32'h000000AB;
    issue(1'b0, 3'b100, 32'h11, 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ack_manual = 1'b1;
      chk($sformatf("ws_stable%0d", k),
          {bus.mem_addr[27:0], bus.mem_funct3, bus.mem_req},
          {28'h11, 3'b100, 1'b1});
      chk($sformatf("ws_no_wr%0d", k), 32'(bus.mem_wr_en), 32'd0);
      @(posedge clk); #1;
    end
    ack_manual = 1'b0; force_rd = 1'b0;
    chk("ws_resp", {bus.resp_rdata[30:0], bus.resp_valid}, {31'hAB, 1'b1});
    chk("ws_err", 32'(bus.resp_err), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a store access
    w0 = wr_cycles;
    issue(1'b1, 3'b000, 32'h30, 32'h00000077);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", 32'({bus.mem_req, bus.mem_wr_en, bus.req_ready}), 32'b001);
    ack_manual = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_req", 32'(bus.mem_req), 32'd0);
    snap = mem_arr[12];
    chk("mid_rst_mem_intact", snap, 32'h1000000C);
    ack_manual = 1'b0;

    // Access with no ack at all
    issue(1'b0, 3'b010, 32'h00, 32'h0);
    n = 0;
`ifdef LSU_TIMEOUT_EN
    while (bus.mem_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_resp", 32'({bus.resp_valid, bus.resp_err}), 32'b11);
    chk("tmo_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;
`else
    while (bus.mem_req && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("no_tmo_waiting", 32'({bus.mem_req, bus.resp_valid}), 32'b10);
    chk("no_tmo_cycles", 32'(n), 32'd100);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`endif
    chk("end_idle", 32'({bus.req_ready, bus.mem_req}), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
